// File: rtl/sm2201_bridge_pkg.sv
// sm2201_bridge_pkg: register offsets, FSM encoding, status bits and timing defaults for the SM2201 bridge.
package sm2201_bridge_pkg;
  localparam logic [2:0] OFF_ADDR_LO = 3'd0;
  localparam logic [2:0] OFF_ADDR_HI = 3'd1;
  localparam logic [2:0] OFF_WR_LO   = 3'd2;
  localparam logic [2:0] OFF_WR_HI   = 3'd3;
  localparam logic [2:0] OFF_RD_LO   = 3'd4;
  localparam logic [2:0] OFF_RD_HI   = 3'd5;
  localparam logic [2:0] OFF_STATUS  = 3'd6;
  localparam int ST_BUSY    = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_OVERRUN = 2;
  localparam int DEF_STROBE_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  typedef enum logic [1:0] {IDLE, RD_STROBE, RD_DONE, WR_STROBE} state_e;
endpackage

// File: rtl/sm2201_camac_cycle.sv
// sm2201_camac_cycle: one CAMAC strobe with minimum width, cb_prr handshake, timeout and read capture.
module sm2201_camac_cycle
  import sm2201_bridge_pkg::*;
#(
  parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        is_write_i,
  input  logic        cb_prr_i,
  input  logic [15:0] cb_data_in_i,
  output logic        done_o,
  output logic        timed_out_o,
  output logic [15:0] rd_data_o,
  output logic        cb_b_b1_o,
  output logic        cb_data_oe_o
);
  localparam logic [7:0] S_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] T_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic        active_q, wr_q, ok, tmo;
  logic [7:0]  cnt_q;
  logic [15:0] rd_q;
  assign ok           = cnt_q >= S_LAST && !cb_prr_i;
  assign tmo          = !ok && cnt_q == T_LAST;
  assign done_o       = active_q && (ok || tmo);
  assign timed_out_o  = active_q && tmo;
  assign rd_data_o    = rd_q;
  assign cb_b_b1_o    = !active_q;
  assign cb_data_oe_o = active_q && wr_q;
  // a start coinciding with done chains a queued read straight onto the finishing write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      active_q <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 8'd0;
      rd_q     <= 16'd0;
    end else begin
      if (start_i) begin
        active_q <= 1'b1;
        wr_q     <= is_write_i;
        cnt_q    <= 8'd0;
      end else if (done_o) active_q <= 1'b0;
      else if (active_q) cnt_q <= cnt_q + 8'd1;
      if (done_o && !wr_q) rd_q <= tmo ? 16'hFFFF : cb_data_in_i;
    end
endmodule

// File: rtl/sm2201_camac_byte_bridge.sv
// sm2201_camac_byte_bridge: ISA 8-bit register window at BASE_ADDR bridged to 16-bit CAMAC cycles.
// SM2201_AUTO_INC_EN: each completed read of offset 5 increments cb_addr (12-bit wrap).
module sm2201_camac_byte_bridge
  import sm2201_bridge_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR      = 10'h100,
  parameter int         STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic [9:0]  isa_addr,
  input  logic        isa_ale,
  input  logic        isa_aen,
  input  logic        isa_ior,
  input  logic        isa_iow,
  input  logic [7:0]  isa_data_in,
  output logic [7:0]  isa_data_out,
  output logic        isa_data_oe,
  output logic        isa_chrdy,
  output logic [11:0] cb_addr,
  input  logic [15:0] cb_data_in,
  output logic [15:0] cb_data_out,
  output logic        cb_data_oe,
  output logic        cb_b_b1,
  input  logic        cb_prr
);
  state_e      state_q, state_d;
  logic [9:0]  addr_q;
  logic        ior_q, ior_p_q, iow_q, iow_p_q, pend_q, pend_d;
  logic [11:0] cb_addr_q;
  logic [7:0]  wr_lo_q, wr_hi_q, status, rd_mux;
  logic        timeout_q, overrun_q;
  logic        sel, ior_fall, ior_rise, iow_rise, rd_go, wr_go, stat_clr, busy;
  logic        start, is_write, cyc_done, cyc_tmo;
  logic [15:0] rd_word;
  logic [2:0]  off;
  assign off      = addr_q[2:0];
  assign sel      = addr_q[9:3] == BASE_ADDR[9:3] && !isa_aen;
  assign ior_fall = ior_p_q && !ior_q;
  assign ior_rise = !ior_p_q && ior_q;
  assign iow_rise = !iow_p_q && iow_q;
  assign rd_go    = ior_fall && sel && off == OFF_RD_LO;
  assign wr_go    = iow_rise && sel && off == OFF_WR_HI;
  assign stat_clr = ior_rise && sel && off == OFF_STATUS;
  assign busy     = state_q == WR_STROBE;
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    start    = 1'b0;
    is_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_go) begin
          state_d = RD_STROBE;
          start   = 1'b1;
        end else if (wr_go) begin
          state_d  = WR_STROBE;
          start    = 1'b1;
          is_write = 1'b1;
        end
      end
      RD_STROBE: state_d = cyc_done ? RD_DONE : RD_STROBE;
      RD_DONE:   state_d = ior_rise ? IDLE : RD_DONE;
      WR_STROBE: begin
        pend_d = pend_q || rd_go;
        if (cyc_done) begin
          state_d = pend_d ? RD_STROBE : IDLE;
          start   = pend_d;
          pend_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge isa_clk or posedge isa_reset)
    if (isa_reset) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      addr_q    <= 10'd0;
      ior_q     <= 1'b0;
      ior_p_q   <= 1'b0;
      iow_q     <= 1'b0;
      iow_p_q   <= 1'b0;
      cb_addr_q <= 12'd0;
      wr_lo_q   <= 8'd0;
      wr_hi_q   <= 8'd0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ior_q   <= isa_ior;
      ior_p_q <= ior_q;
      iow_q   <= isa_iow;
      iow_p_q <= iow_q;
      if (isa_ale) addr_q <= isa_addr;
      if (iow_rise && sel && off == OFF_ADDR_LO) cb_addr_q[7:0] <= isa_data_in;
      if (iow_rise && sel && off == OFF_ADDR_HI) cb_addr_q[11:8] <= isa_data_in[3:0];
      if (iow_rise && sel && off == OFF_WR_LO) wr_lo_q <= isa_data_in;
      if (wr_go && state_q == IDLE) wr_hi_q <= isa_data_in;
`ifdef SM2201_AUTO_INC_EN
      if (ior_rise && sel && off == OFF_RD_HI) cb_addr_q <= cb_addr_q + 12'd1;
`endif
      timeout_q <= cyc_tmo || (timeout_q && !stat_clr);
      overrun_q <= (wr_go && state_q != IDLE) || (overrun_q && !stat_clr);
    end
  sm2201_camac_cycle #(
    .STROBE_CYCLES (STROBE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_cycle (
    .clk         (isa_clk),
    .rst         (isa_reset),
    .start_i     (start),
    .is_write_i  (is_write),
    .cb_prr_i    (cb_prr),
    .cb_data_in_i(cb_data_in),
    .done_o      (cyc_done),
    .timed_out_o (cyc_tmo),
    .rd_data_o   (rd_word),
    .cb_b_b1_o   (cb_b_b1),
    .cb_data_oe_o(cb_data_oe)
  );
  always_comb begin
    status                 = 8'h00;
    status[ST_BUSY]        = busy;
    status[ST_TIMEOUT]     = timeout_q;
    status[ST_OVERRUN]     = overrun_q;
  end
  assign rd_mux = off == OFF_RD_LO ? rd_word[7:0] : off == OFF_RD_HI ? rd_word[15:8] :
                  off == OFF_STATUS ? status : 8'h00;
  // offset 4 stays off the bus until its CAMAC read has landed
  assign isa_data_oe  = !ior_q && sel && !(off == OFF_RD_LO && state_q != RD_DONE);
  assign isa_data_out = isa_data_oe ? rd_mux : 8'h00;
  assign isa_chrdy    = !(state_q == RD_STROBE || pend_q);
  assign cb_addr      = cb_addr_q;
  assign cb_data_out  = {wr_hi_q, wr_lo_q};
endmodule

// File: tb/tb_sm2201_camac_byte_bridge.sv
// tb_sm2201_camac_byte_bridge: directed scoreboard bench for the SM2201 ISA-to-CAMAC bridge.
module tb_sm2201_camac_byte_bridge;
  logic        isa_clk = 1'b0, isa_reset = 1'b1;
  logic [9:0]  isa_addr = 10'd0;
  logic        isa_ale = 1'b0, isa_aen = 1'b0, isa_ior = 1'b1, isa_iow = 1'b1;
  logic [7:0]  isa_data_in = 8'd0, isa_data_out;
  logic        isa_data_oe, isa_chrdy, cb_data_oe, cb_b_b1, cb_prr = 1'b0;
  logic [11:0] cb_addr;
  logic [15:0] cb_data_in = 16'd0, cb_data_out;
  int checks = 0, errors = 0;
  int strobe_lo = 0, wait_lo = 0, doe_bad = 0;
  int s0, w0;
  logic [7:0] sb_q[$];
`ifdef SM2201_AUTO_INC_EN
  localparam logic [11:0] ADDR_AFTER_RD5 = 12'h235;
`else
  localparam logic [11:0] ADDR_AFTER_RD5 = 12'h234;
`endif

  sm2201_camac_byte_bridge dut (
    .isa_clk(isa_clk), .isa_reset(isa_reset), .isa_addr(isa_addr), .isa_ale(isa_ale),
    .isa_aen(isa_aen), .isa_ior(isa_ior), .isa_iow(isa_iow), .isa_data_in(isa_data_in),
    .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe), .isa_chrdy(isa_chrdy),
    .cb_addr(cb_addr), .cb_data_in(cb_data_in), .cb_data_out(cb_data_out),
    .cb_data_oe(cb_data_oe), .cb_b_b1(cb_b_b1), .cb_prr(cb_prr)
  );

  always #5 isa_clk = ~isa_clk;

  always @(negedge isa_clk) begin
    if (!cb_b_b1) strobe_lo++;
    if (!isa_chrdy) wait_lo++;
    if (cb_data_oe && cb_b_b1) doe_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge isa_clk);
    #1;
  endtask

  task automatic set_addr(input logic [9:0] a);
    isa_addr = a;
    isa_ale  = 1'b1;
    tick(1);
    isa_ale  = 1'b0;
  endtask

  task automatic isa_write(input logic [9:0] a, input logic [7:0] d);
    set_addr(a);
    isa_data_in = d;
    isa_iow = 1'b0;
    tick(2);
    isa_iow = 1'b1;
    tick(3);
  endtask

  task automatic isa_read(input logic [9:0] a, output logic [7:0] d, output logic oe);
    int n;
    set_addr(a);
    isa_ior = 1'b0;
    tick(2);
    n = 0;
    while (!isa_chrdy && n < 2000) begin
      tick(1);
      n++;
    end
    chk("chrdy_bound", 32'(n >= 2000), 32'd0);
    @(negedge isa_clk);
    d  = isa_data_out;
    oe = isa_data_oe;
    @(posedge isa_clk);
    #1 isa_ior = 1'b1;
    tick(3);
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic oe;
    sb_q.push_back(exp);
    isa_read(a, d, oe);
    chk({tag, "_oe"}, 32'(oe), 32'd1);
    chk(tag, 32'(d), 32'(sb_q.pop_front()));
    chk({tag, "_oe_after"}, 32'(isa_data_oe), 32'd0);
  endtask

  initial begin
    tick(2);
    chk("rst_data_out", 32'(isa_data_out), 32'h00);
    chk("rst_data_oe", 32'(isa_data_oe), 32'd0);
    chk("rst_chrdy", 32'(isa_chrdy), 32'd1);
    chk("rst_cb_addr", 32'(cb_addr), 32'h000);
    chk("rst_cb_data_out", 32'(cb_data_out), 32'h0000);
    chk("rst_cb_data_oe", 32'(cb_data_oe), 32'd0);
    chk("rst_cb_b_b1", 32'(cb_b_b1), 32'd1);
    isa_reset = 1'b0;
    tick(3);
    s0 = strobe_lo; w0 = wait_lo;
    rd_chk("status_idle0", 10'h106, 8'h00);
    rd_chk("status_idle1", 10'h106, 8'h00);
    chk("idle_strobe", 32'(strobe_lo - s0), 32'd0);
    chk("idle_wait", 32'(wait_lo - w0), 32'd0);

    isa_write(10'h100, 8'h34);
    isa_write(10'h101, 8'h02);
    chk("cb_addr", 32'(cb_addr), 32'h234);
    cb_data_in = 16'hABCD;
    cb_prr = 1'b0;
    s0 = strobe_lo; w0 = wait_lo;
    rd_chk("rd_lo", 10'h104, 8'hCD);
    chk("rd_strobe_len", 32'(strobe_lo - s0), 32'd4);
    chk("rd_wait_len", 32'(wait_lo - w0), 32'd4);
    rd_chk("rd_hi", 10'h105, 8'hAB);
    chk("cb_addr_after_rd5", 32'(cb_addr), 32'(ADDR_AFTER_RD5));

    cb_prr = 1'b1;
    isa_write(10'h102, 8'h56);
    isa_write(10'h103, 8'h12);
    chk("wr_data", 32'(cb_data_out), 32'h1256);
    chk("wr_data_oe", 32'(cb_data_oe), 32'd1);
    chk("wr_strobe", 32'(cb_b_b1), 32'd0);
    rd_chk("status_busy", 10'h106, 8'h01);
    cb_prr = 1'b0;
    tick(3);
    chk("wr_done_oe", 32'(cb_data_oe), 32'd0);
    chk("wr_done_strobe", 32'(cb_b_b1), 32'd1);
    rd_chk("status_after_wr", 10'h106, 8'h00);

    cb_prr = 1'b1;
    s0 = strobe_lo;
    rd_chk("tmo_lo", 10'h104, 8'hFF);
    chk("tmo_strobe_len", 32'(strobe_lo - s0), 32'd255);
    rd_chk("tmo_hi", 10'h105, 8'hFF);
    rd_chk("status_tmo", 10'h106, 8'h02);
    rd_chk("status_tmo_clr", 10'h106, 8'h00);

    isa_write(10'h102, 8'h00);
    s0 = strobe_lo;
    isa_write(10'h103, 8'h77);
    isa_write(10'h103, 8'h88);
    chk("ovr_data_kept", 32'(cb_data_out), 32'h7700);
    rd_chk("status_ovr", 10'h106, 8'h05);
    w0 = wait_lo;
    rd_chk("rd_behind_wr", 10'h104, 8'hFF);
    chk("behind_strobe_len", 32'(strobe_lo - s0), 32'd510);
    chk("behind_wait_long", 32'(wait_lo - w0 > 400), 32'd1);
    rd_chk("status_after_ovr", 10'h106, 8'h02);
    cb_prr = 1'b0;

    s0 = strobe_lo;
    set_addr(10'h104);
    isa_aen = 1'b1;
    isa_ior = 1'b0;
    tick(4);
    chk("dma_oe", 32'(isa_data_oe), 32'd0);
    chk("dma_data", 32'(isa_data_out), 32'h00);
    chk("dma_chrdy", 32'(isa_chrdy), 32'd1);
    isa_ior = 1'b1;
    tick(3);
    isa_aen = 1'b0;
    chk("dma_strobe", 32'(strobe_lo - s0), 32'd0);

    cb_prr = 1'b1;
    set_addr(10'h104);
    isa_ior = 1'b0;
    tick(4);
    chk("mid_rd_strobe", 32'(cb_b_b1), 32'd0);
    chk("mid_rd_chrdy", 32'(isa_chrdy), 32'd0);
    #2 isa_reset = 1'b1;
    #1;
    chk("arst_cb_b_b1", 32'(cb_b_b1), 32'd1);
    chk("arst_chrdy", 32'(isa_chrdy), 32'd1);
    chk("arst_cb_addr", 32'(cb_addr), 32'h000);
    chk("arst_cb_data_out", 32'(cb_data_out), 32'h0000);
    chk("arst_data_oe", 32'(isa_data_oe), 32'd0);
    chk("arst_data_out", 32'(isa_data_out), 32'h00);
    tick(2);
    isa_reset = 1'b0;
    isa_ior = 1'b1;
    cb_prr = 1'b0;
    tick(3);
    rd_chk("status_post_rst", 10'h106, 8'h00);
    chk("doe_outside_strobe", 32'(doe_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
